// File: rtl/addsub_result_display.sv
// addsub_result_display: captures {mode, carry, sum} results of the 3-bit
// adder/subtractor on a pushbutton strobe. It keeps the last DEPTH results and
// scrolls them, oldest first, on one 7-segment digit followed by a blank gap.
// Optional macro ADDSUB_SIGNED_EN: shows a negative subtract result as a
// magnitude with the decimal point used as a minus sign.
module addsub_result_display #(
    parameter int DEPTH       = 4,
    parameter int SCROLL_DIV  = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               res_in,
    input  logic                     mode_in,
    input  logic                     strobe,
    output logic [6:0]               seg,
    output logic                     dp,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] flush_q;
    logic                   armed_q;
    logic                   level_q;
    logic                   push_q;

    logic [4:0]             hist [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          idx;
    logic [SCROLL_DIV-1:0]  dwell;
    state_t                 state;

    state_t                 n_state;
    logic [PW-1:0]          n_idx;
    logic [PW-1:0]          n_wr;
    logic [PW:0]            n_count;
    logic [SCROLL_DIV-1:0]  n_dwell;
    logic [PW-1:0]          phys;
    logic [4:0]             disp;
    logic [7:0]             disp_code;
    logic                   full;

    // Segment pattern of a hex digit (seg[0]=a .. seg[6]=g).
    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_seg = 7'h3F;  4'h1: hex_seg = 7'h06;
            4'h2: hex_seg = 7'h5B;  4'h3: hex_seg = 7'h4F;
            4'h4: hex_seg = 7'h66;  4'h5: hex_seg = 7'h6D;
            4'h6: hex_seg = 7'h7D;  4'h7: hex_seg = 7'h07;
            4'h8: hex_seg = 7'h7F;  4'h9: hex_seg = 7'h6F;
            4'hA: hex_seg = 7'h77;  4'hB: hex_seg = 7'h7C;
            4'hC: hex_seg = 7'h39;  4'hD: hex_seg = 7'h5E;
            4'hE: hex_seg = 7'h79;  default: hex_seg = 7'h71;
        endcase
    endfunction

    // Returns {dp, seg} for a stored entry {mode, carry, sum[2:0]}.
    function automatic logic [7:0] decode(input logic [4:0] e);
        logic [2:0] mag;
        mag = 3'd0;
        if (!e[4]) begin
            decode = {1'b0, hex_seg(e[3:0])};
        end else if (e[3]) begin
            decode = {1'b0, hex_seg({1'b0, e[2:0]})};
        end else begin
`ifdef ADDSUB_SIGNED_EN
            mag    = 3'd0 - e[2:0];
            decode = {1'b1, hex_seg({1'b0, mag})};
`else
            decode = {1'b0, hex_seg(e[3:0])};
`endif
        end
    endfunction

    // Strobe synchroniser and one-shot rising-edge detector. armed_q blocks
    // pushes until the flushed synchroniser has seen the strobe low, so a
    // button held through reset release is not taken as a new press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            flush_q <= '0;
            armed_q <= 1'b0;
            level_q <= 1'b0;
            push_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], strobe};
            flush_q <= {flush_q[SYNC_STAGES-2:0], 1'b1};
            if (flush_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1])
                armed_q <= 1'b1;
            level_q <= sync_q[SYNC_STAGES-1];
            push_q  <= sync_q[SYNC_STAGES-1] & ~level_q & armed_q;
        end
    end

    // Next-state of scroll FSM, buffer pointers, and the entry to display.
    always_comb begin
        full    = (count == FULL_CNT);
        n_state = state;
        n_idx   = idx;
        n_wr    = wr_ptr;
        n_count = count;
        n_dwell = dwell;
        case (state)
            IDLE: begin
                if (push_q) begin
                    n_state = SHOW;
                    n_idx   = '0;
                    n_dwell = '0;
                end
            end
            SHOW: begin
                n_dwell = dwell + SCROLL_DIV'(1);
                if (dwell == '1) begin
                    if (({1'b0, idx} + (PW+1)'(1)) < count)
                        n_idx = idx + PW'(1);
                    else
                        n_state = GAP;
                end
            end
            default: begin
                n_dwell = dwell + SCROLL_DIV'(1);
                if (dwell == '1) begin
                    n_state = SHOW;
                    n_idx   = '0;
                end
            end
        endcase
        if (push_q) begin
            n_wr = wr_ptr + PW'(1);
            if (!full)
                n_count = count + (PW+1)'(1);
            else if (n_state == SHOW && n_idx != '0)
                // Oldest entry dropped: shift the logical index so the
                // physically displayed entry stays the same.
                n_idx = n_idx - PW'(1);
        end
        // Oldest physical slot is n_wr - n_count (mod DEPTH).
        phys = n_wr - n_count[PW-1:0] + n_idx;
        disp = (push_q && phys == wr_ptr) ? {mode_in, res_in} : hist[phys];
        case (n_state)
            IDLE:    disp_code = 8'h40;
            SHOW:    disp_code = decode(disp);
            default: disp_code = 8'h00;
        endcase
    end

    // State, history buffer and registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                hist[i] <= '0;
            wr_ptr <= '0;
            idx    <= '0;
            dwell  <= '0;
            count  <= '0;
            state  <= IDLE;
            seg    <= 7'h40;
            dp     <= 1'b0;
        end else begin
            if (push_q)
                hist[wr_ptr] <= {mode_in, res_in};
            wr_ptr <= n_wr;
            idx    <= n_idx;
            dwell  <= n_dwell;
            count  <= n_count;
            state  <= n_state;
            seg    <= disp_code[6:0];
            dp     <= disp_code[7];
        end
    end

endmodule

// File: tb/tb_addsub_result_display.sv
// Directed-vector bench for addsub_result_display (DEPTH=4, SCROLL_DIV=2,
// SYNC_STAGES=2): inputs driven and outputs sampled on the falling edge.
module tb_addsub_result_display;

    logic       clk;
    logic       reset;
    logic [3:0] res_in;
    logic       mode_in;
    logic       strobe;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] count;

    int checks;
    int fails;

    addsub_result_display #(
        .DEPTH(4),
        .SCROLL_DIV(2),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .res_in(res_in),
        .mode_in(mode_in),
        .strobe(strobe),
        .seg(seg),
        .dp(dp),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] r, input logic m);
        res_in  = r;
        mode_in = m;
        strobe  = 1'b1;
        step(3);
        strobe  = 1'b0;
        step(3);
    endtask

    task automatic test_reset();
        strobe = 1'b0; res_in = '0; mode_in = 1'b0;
        do_reset();
        for (int i = 0; i < 50; i++) begin
            checks++;
            if (seg !== 7'h40 || dp !== 1'b0 || count !== 3'd0) begin
                fails++;
                $display("FAIL reset_idle cyc %0d: seg=%h dp=%b count=%0d, expected seg=40 dp=0 count=0", i, seg, dp, count);
            end
            step(1);
        end
    endtask

    task automatic test_add_single();
        logic [6:0] exp_seg;
        do_reset();
        step(5);
        res_in = 4'b1010; mode_in = 1'b0; strobe = 1'b1;
        step(3);
        checks++;
        if (count !== 3'd0) begin
            fails++;
            $display("FAIL push_latency: count=%0d, expected 0", count);
        end
        strobe = 1'b0;
        step(1);
        checks++;
        if (count !== 3'd1 || seg !== 7'h77 || dp !== 1'b0) begin
            fails++;
            $display("FAIL add_first: seg=%h dp=%b count=%0d, expected seg=77 dp=0 count=1", seg, dp, count);
        end
        for (int k = 1; k < 16; k++) begin
            step(1);
            exp_seg = ((k / 4) % 2 == 0) ? 7'h77 : 7'h00;
            checks++;
            if (seg !== exp_seg || dp !== 1'b0) begin
                fails++;
                $display("FAIL add_blink cyc %0d: seg=%h dp=%b, expected seg=%h dp=0", k, seg, dp, exp_seg);
            end
        end
    endtask

    task automatic test_subtract();
        logic [6:0] exp_seg;
        logic       exp_dp;
`ifdef ADDSUB_SIGNED_EN
        exp_seg = 7'h4F; exp_dp = 1'b1;
`else
        exp_seg = 7'h6D; exp_dp = 1'b0;
`endif
        do_reset();
        step(5);
        pulse(4'b0101, 1'b1);
        checks++;
        if (seg !== exp_seg || dp !== exp_dp || count !== 3'd1) begin
            fails++;
            $display("FAIL sub_negative: seg=%h dp=%b count=%0d, expected seg=%h dp=%b count=1", seg, dp, count, exp_seg, exp_dp);
        end
        do_reset();
        step(5);
        pulse(4'b1011, 1'b1);
        checks++;
        if (seg !== 7'h4F || dp !== 1'b0) begin
            fails++;
            $display("FAIL sub_positive: seg=%h dp=%b, expected seg=4F dp=0", seg, dp);
        end
    endtask

    task automatic test_scroll_overwrite();
        logic [6:0] exp_tab [5];
        int         waited;
        exp_tab[0] = 7'h5B; exp_tab[1] = 7'h4F; exp_tab[2] = 7'h66;
        exp_tab[3] = 7'h6D; exp_tab[4] = 7'h00;
        do_reset();
        step(5);
        for (int v = 1; v <= 5; v++)
            pulse(4'(v), 1'b0);
        checks++;
        if (count !== 3'd4) begin
            fails++;
            $display("FAIL full_count: count=%0d, expected 4", count);
        end
        waited = 0;
        while (seg !== 7'h00 && waited < 40) begin step(1); waited++; end
        while (seg === 7'h00 && waited < 40) begin step(1); waited++; end
        checks++;
        if (waited >= 40) begin
            fails++;
            $display("FAIL scroll_sync: waited %0d cycles, expected gap then digit within 40", waited);
        end
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (seg !== exp_tab[(k / 4) % 5] || dp !== 1'b0) begin
                fails++;
                $display("FAIL scroll_seq cyc %0d: seg=%h dp=%b, expected seg=%h dp=0", k, seg, dp, exp_tab[(k / 4) % 5]);
            end
            step(1);
        end
    endtask

    task automatic test_held_strobe();
        do_reset();
        step(5);
        res_in = 4'h3; mode_in = 1'b0; strobe = 1'b1;
        step(40);
        strobe = 1'b0;
        step(4);
        checks++;
        if (count !== 3'd1) begin
            fails++;
            $display("FAIL held_strobe: count=%0d, expected 1", count);
        end
        pulse(4'h7, 1'b0);
        checks++;
        if (count !== 3'd2) begin
            fails++;
            $display("FAIL second_edge: count=%0d, expected 2", count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(5);
        pulse(4'h1, 1'b0);
        pulse(4'h2, 1'b0);
        pulse(4'h3, 1'b0);
        step(3);
        checks++;
        if (count !== 3'd3) begin
            fails++;
            $display("FAIL pre_reset_count: count=%0d, expected 3", count);
        end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++;
        if (seg !== 7'h40 || dp !== 1'b0 || count !== 3'd0) begin
            fails++;
            $display("FAIL reset_mid: seg=%h dp=%b count=%0d, expected seg=40 dp=0 count=0", seg, dp, count);
        end
        step(10);
        checks++;
        if (seg !== 7'h40 || count !== 3'd0) begin
            fails++;
            $display("FAIL reset_mid_idle: seg=%h count=%0d, expected seg=40 count=0", seg, count);
        end
    endtask

    task automatic test_strobe_through_reset();
        strobe = 1'b1;
        res_in = 4'h9; mode_in = 1'b0;
        do_reset();
        step(20);
        checks++;
        if (count !== 3'd0 || seg !== 7'h40) begin
            fails++;
            $display("FAIL strobe_thru_reset: seg=%h count=%0d, expected seg=40 count=0", seg, count);
        end
        strobe = 1'b0;
        step(5);
        pulse(4'h9, 1'b0);
        checks++;
        if (count !== 3'd1 || seg !== 7'h6F) begin
            fails++;
            $display("FAIL rearm_push: seg=%h count=%0d, expected seg=6F count=1", seg, count);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        reset  = 1'b1;
        strobe = 1'b0;
        res_in = '0;
        mode_in = 1'b0;
        test_reset();
        test_add_single();
        test_subtract();
        test_scroll_overwrite();
        test_held_strobe();
        test_reset_mid();
        test_strobe_through_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
